// File: rtl/ladybird_inst_fetch.sv
// ladybird_inst_fetch: sequential instruction fetch primary with pipelined in-order reads,
// a PC-tagged instruction queue and redirect with drop of stale in-flight responses.
package ladybird_config;
  localparam int XLEN = 32;
endpackage

interface ladybird_bus;
  logic req, gnt, data_gnt;
  logic [ladybird_config::XLEN-1:0] addr;
  logic [ladybird_config::XLEN/8-1:0] wstrb;
  wire [ladybird_config::XLEN-1:0] data;
  modport primary (output req, addr, wstrb, input gnt, data_gnt, inout data);
  modport secondary (input req, addr, wstrb, output gnt, data_gnt, inout data);
endinterface

module ladybird_inst_fetch import ladybird_config::*; #(
  parameter int QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nrst,
  ladybird_bus.primary    bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  logic [XLEN-1:0] fetch_pc, resp_pc, redirect_base;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW:0] in_use;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [XLEN-1:0] q_data [QUEUE_DEPTH];
  logic [XLEN-1:0] q_pc [QUEUE_DEPTH];
  logic accept, push, pop, unused_bits;
  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];
  // Queue slots are reserved at issue time, so a returning word always has room.
  assign in_use = {1'b0, count} + {1'b0, outstanding};
  assign bus.req = nrst & ~redirect_valid & (in_use < (CW+1)'(QUEUE_DEPTH));
  assign bus.addr = {fetch_pc[XLEN-1:2], 2'b00};
  assign bus.wstrb = '0;
  assign bus.data = 'z;
  assign accept = bus.req & bus.gnt;
  assign push = bus.data_gnt & ~redirect_valid & (drop_cnt == '0);
  assign pop = inst_valid & inst_ready & ~redirect_valid;
  assign inst_valid = count != '0;
  assign inst_data = q_data[rd_ptr];
  assign inst_pc = q_pc[rd_ptr];
  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.data_gnt);
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        resp_pc <= redirect_base;
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        drop_cnt <= outstanding - CW'(bus.data_gnt);
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) resp_pc <= resp_pc + XLEN'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (bus.data_gnt && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.data;
      q_pc[wr_ptr] <= resp_pc;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(push && count == CW'(QUEUE_DEPTH)));
endmodule

// File: tb/tb_ladybird_inst_fetch.sv
// tb_ladybird_inst_fetch: fetch unit against a 1/2-cycle instruction RAM responder,
// checked by a PC-sequence reference model.
module tb_ladybird_inst_fetch;
  logic clk = 0, nrst = 0;
  always #5 clk = ~clk;
  logic redirect_valid = 0, inst_ready = 0, inst_valid, gnt_drv = 1;
  logic [31:0] redirect_pc = '0, inst_data, inst_pc;
  int total = 0, bad = 0, lat = 1;
  ladybird_bus bus();
  ladybird_inst_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc));
  logic p1_v = 0, p2_v = 0;
  logic [31:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    if (!nrst) begin
      p1_v <= 0;
      p2_v <= 0;
    end else begin
      p1_v <= bus.req & bus.gnt;
      p1_a <= bus.addr;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end
  assign bus.gnt = gnt_drv;
  assign bus.data_gnt = lat == 1 ? p1_v : p2_v;
  assign bus.data = 32'h1000_0000 + ((lat == 1 ? p1_a : p2_a) >> 2);

  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic r);
    nrst = 0;
    lat = l;
    gnt_drv = 1;
    inst_ready = r;
    redirect_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
  endtask

  task automatic test_reset;
    nrst = 0;
    repeat (2) @(posedge clk);
    #2;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.req); end
    total++; if (bus.wstrb !== 4'h0) begin bad++; $display("FAIL reset_wstrb got=%h want=0", bus.wstrb); end
  endtask

  task automatic test_stream_lat1;
    logic [31:0] a, p;
    do_reset(1, 1);
    for (int k = 0; k < 16; k++) begin
      #1;
      a = 32'(4 * k);
      p = 32'(4 * (k - 2));
      total++; if (bus.req !== 1'b1 || bus.addr !== a) begin bad++; $display("FAIL lat1_addr cyc=%0d got=%b/%h want=1/%h", k, bus.req, bus.addr, a); end
      total++; if (inst_valid !== (k >= 2)) begin bad++; $display("FAIL lat1_valid cyc=%0d got=%b want=%b", k, inst_valid, k >= 2); end
      if (k >= 2) begin
        total++; if (inst_pc !== p || inst_data !== word(p)) begin bad++; $display("FAIL lat1_word cyc=%0d got=%h/%h want=%h/%h", k, inst_pc, inst_data, p, word(p)); end
      end
      step();
    end
  endtask

  task automatic test_stream_lat2;
    logic [31:0] exp_pc = 0;
    int seen = 0, gaps = 0, out = 0, max_out = 0;
    do_reset(2, 1);
    for (int k = 0; k < 40; k++) begin
      #1;
      if (seen != 0 && !inst_valid) gaps++;
      if (inst_valid) seen = 1;
      if (inst_valid && inst_ready) begin
        total++; if (inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin bad++; $display("FAIL lat2_word got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, word(exp_pc)); end
        exp_pc += 4;
      end
      out += int'(bus.req & bus.gnt) - int'(bus.data_gnt);
      if (out > max_out) max_out = out;
      step();
    end
    total++; if (seen == 0 || gaps != 0) begin bad++; $display("FAIL lat2_gaps got=%0d want=0", gaps); end
    total++; if (max_out > 4) begin bad++; $display("FAIL lat2_outstanding got=%0d want<=4", max_out); end
    total++; if (exp_pc !== 32'(37 * 4)) begin bad++; $display("FAIL lat2_throughput got=%h want=%h", exp_pc, 37 * 4); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_pc = 0;
    int acc = 0;
    do_reset(1, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.req && bus.gnt) begin
        total++; if (bus.addr !== 32'(4 * acc)) begin bad++; $display("FAIL bp_addr got=%h want=%h", bus.addr, 4 * acc); end
        acc++;
      end
      step();
    end
    total++; if (acc != 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", acc); end
    #1;
    total++; if (bus.req !== 1'b0 || inst_valid !== 1'b1) begin bad++; $display("FAIL bp_full got=%b/%b want=0/1", bus.req, inst_valid); end
    inst_ready = 1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (inst_valid && inst_ready) begin
        total++; if (inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin bad++; $display("FAIL bp_word got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, word(exp_pc)); end
        exp_pc += 4;
      end
      if (bus.req && bus.gnt) begin
        total++; if (bus.addr !== 32'(4 * acc)) begin bad++; $display("FAIL bp_resume got=%h want=%h", bus.addr, 4 * acc); end
        acc++;
      end
      step();
    end
    total++; if (exp_pc <= 32'h10 || acc <= 4) begin bad++; $display("FAIL bp_drain got=%h/%0d want>10/>4", exp_pc, acc); end
  endtask

  task automatic test_redirect;
    do_reset(2, 1);
    step();
    step();
    redirect_valid = 1;
    redirect_pc = 32'h43;
    #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b want=0", bus.req); end
    step();
    redirect_valid = 0;
    #1;
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%b/%h want=1/40", bus.req, bus.addr); end
    for (int k = 3; k <= 6; k++) begin
      total++; if (inst_valid !== (k == 6)) begin bad++; $display("FAIL redir_valid cyc=%0d got=%b want=%b", k, inst_valid, k == 6); end
      if (k < 6) begin
        step();
        #1;
      end
    end
    total++; if (inst_pc !== 32'h40 || inst_data !== 32'h1000_0010) begin bad++; $display("FAIL redir_word got=%h/%h want=40/10000010", inst_pc, inst_data); end
    step();
  endtask

  task automatic test_gnt_stall;
    logic [31:0] exp_pc = 0, hold_a = 0;
    do_reset(1, 1);
    for (int k = 0; k < 20; k++) begin
      gnt_drv = !(k >= 6 && k < 9);
      #1;
      if (k == 6) hold_a = bus.addr;
      if (k >= 6 && k < 9) begin
        total++; if (bus.req !== 1'b1 || bus.addr !== hold_a) begin bad++; $display("FAIL stall_addr got=%b/%h want=1/%h", bus.req, bus.addr, hold_a); end
      end
      if (k >= 9 && bus.req && bus.gnt) begin
        total++; if (bus.addr !== hold_a) begin bad++; $display("FAIL stall_resume got=%h want=%h", bus.addr, hold_a); end
        hold_a += 4;
      end
      if (inst_valid && inst_ready) begin
        total++; if (inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin bad++; $display("FAIL stall_word got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, word(exp_pc)); end
        exp_pc += 4;
      end
      step();
    end
    total++; if (exp_pc < 32'h30) begin bad++; $display("FAIL stall_progress got=%h want>=30", exp_pc); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_pc = 0;
    do_reset(1, 1);
    repeat (6) step();
    nrst = 0;
    step();
    total++; if (inst_valid !== 1'b0 || bus.req !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b/%b want=0/0", inst_valid, bus.req); end
    nrst = 1;
    #1;
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%b/%h want=1/0", bus.req, bus.addr); end
    for (int k = 0; k < 8; k++) begin
      if (inst_valid && inst_ready) begin
        total++; if (inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin bad++; $display("FAIL midrst_word got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, word(exp_pc)); end
        exp_pc += 4;
      end
      step();
      #1;
    end
    total++; if (exp_pc !== 32'h18) begin bad++; $display("FAIL midrst_count got=%h want=18", exp_pc); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      logic [31:0] exp_pc = 0, exp_fetch = 0;
      int out = 0, max_out = 0, hs = 0;
      do_reset(int'($urandom_range(1, 2)), 1);
      for (int k = 0; k < 300; k++) begin
        gnt_drv = ($urandom % 4) != 0;
        inst_ready = $urandom % 2;
        redirect_valid = ($urandom % 20) == 0;
        redirect_pc = $urandom;
        #1;
        if (redirect_valid) begin
          total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rnd_redir_req got=%b want=0", bus.req); end
          exp_pc = {redirect_pc[31:2], 2'b00};
          exp_fetch = exp_pc;
        end else begin
          if (inst_valid && inst_ready) begin
            total++; if (inst_pc !== exp_pc || inst_data !== word(exp_pc)) begin bad++; $display("FAIL rnd_word got=%h/%h want=%h/%h", inst_pc, inst_data, exp_pc, word(exp_pc)); end
            exp_pc += 4;
            hs++;
          end
          if (bus.req && bus.gnt) begin
            total++; if (bus.addr !== exp_fetch) begin bad++; $display("FAIL rnd_fetch got=%h want=%h", bus.addr, exp_fetch); end
            exp_fetch += 4;
          end
        end
        out += int'(bus.req & bus.gnt) - int'(bus.data_gnt);
        if (out > max_out) max_out = out;
        step();
      end
      redirect_valid = 0;
      total++; if (max_out > 4 || hs == 0) begin bad++; $display("FAIL rnd_bounds got=%0d/%0d want<=4/>0", max_out, hs); end
    end
  endtask

  initial begin
    test_reset();
    test_stream_lat1();
    test_stream_lat2();
    test_backpressure();
    test_redirect();
    test_gnt_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
